// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle sequencer that steers the external 12-bit
// combinational ALU through a shift-and-add 12x12 unsigned multiply
// (24-bit product in {res_hi,res_lo}).
// Build option: define ALU_SEQ_DIV_EN to add a restoring unsigned divide
// (quotient in res_lo, remainder in res_hi), selected per operation by op_div.
// Every operation takes 12 bit iterations of 3 single-cycle ALU steps.
// The done pulse follows 37 cycles after start is accepted.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef ALU_SEQ_DIV_EN
  input  logic        op_div,
`endif
  input  logic [11:0] a_in,
  input  logic [11:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] res_hi,
  output logic [11:0] res_lo,
  output logic [11:0] alu_a,
  output logic [11:0] alu_b,
  output logic [4:0]  alu_op,
  output logic [4:0]  alu_flg,
  input  logic [11:0] alu_q,
  input  logic [4:0]  alu_flg_out
);

  localparam logic [4:0] OP_MOV = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h04;
  localparam logic [4:0] OP_RKR = 5'h0B;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [4:0] OP_SUB = 5'h06;
  localparam logic [4:0] OP_RKL = 5'h0A;
`endif

  localparam logic [3:0] LAST_BIT = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    STEP0,
    STEP1,
    STEP2,
    DONE
  } seqState_e;

  seqState_e   state_q, state_d;
  logic [11:0] hi_q, hi_d;
  logic [11:0] lo_q, lo_d;
  logic [11:0] mc_q, mc_d;
  logic        kReg_q, kReg_d;
  logic [3:0]  cnt_q, cnt_d;
`ifdef ALU_SEQ_DIV_EN
  logic        mode_q, mode_d;
`endif

  // Only the K (carry/borrow/shift-out) flag of the ALU matters here.
  logic kOut;
  logic unusedFlagBits;
  assign kOut           = alu_flg_out[2];
  assign unusedFlagBits = ^{alu_flg_out[4:3], alu_flg_out[1:0]};

  // Result registers are the result outputs, so they hold between operations.
  assign res_hi = hi_q;
  assign res_lo = lo_q;

  // State and datapath registers; synchronous reset clears everything and
  // drops any operation that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
      kReg_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef ALU_SEQ_DIV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mc_q    <= mc_d;
      kReg_q  <= kReg_d;
      cnt_q   <= cnt_d;
`ifdef ALU_SEQ_DIV_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Next-state and ALU drive: each STEPn issues one ALU operation and
  // writes its combinational result back on the same edge.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mc_d    = mc_q;
    kReg_d  = kReg_q;
    cnt_d   = cnt_q;
`ifdef ALU_SEQ_DIV_EN
    mode_d  = mode_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;
    alu_op  = OP_MOV;
    alu_a   = '0;
    alu_b   = '0;
    alu_flg = {2'b00, kReg_q, 2'b00};

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          hi_d    = '0;
          kReg_d  = 1'b0;
          cnt_d   = '0;
          state_d = STEP0;
`ifdef ALU_SEQ_DIV_EN
          mode_d  = op_div;
          if (op_div) begin
            lo_d = a_in;
            mc_d = b_in;
          end else begin
            lo_d = b_in;
            mc_d = a_in;
          end
`else
          lo_d = b_in;
          mc_d = a_in;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      STEP0: begin
        busy    = 1'b1;
        state_d = STEP1;
`ifdef ALU_SEQ_DIV_EN
        if (mode_q) begin
          // Shift the dividend left; the bit leaving lo lands in K.
          alu_op  = OP_RKL;
          alu_b   = lo_q;
          alu_flg = 5'b00000;
          lo_d    = alu_q;
          kReg_d  = kOut;
        end else
`endif
        begin
          // Conditionally add the multiplicand into the upper half.
          alu_op = OP_ADD;
          alu_a  = hi_q;
          alu_b  = lo_q[0] ? mc_q : 12'h000;
          hi_d   = alu_q;
          kReg_d = kOut;
        end
      end

      STEP1: begin
        busy    = 1'b1;
        state_d = STEP2;
`ifdef ALU_SEQ_DIV_EN
        if (mode_q) begin
          // Pull the dividend bit from K into the partial remainder.
          alu_op = OP_RKL;
          alu_b  = hi_q;
          hi_d   = alu_q;
        end else
`endif
        begin
          // Shift the add carry into the top of hi; hi[0] drops into K.
          alu_op = OP_RKR;
          alu_b  = hi_q;
          hi_d   = alu_q;
          kReg_d = kOut;
        end
      end

      STEP2: begin
        busy = 1'b1;
`ifdef ALU_SEQ_DIV_EN
        if (mode_q) begin
          // Trial subtract; keep it and set the quotient bit when no borrow.
          alu_op = OP_SUB;
          alu_a  = hi_q;
          alu_b  = mc_q;
          if (!kOut) begin
            hi_d = alu_q;
            lo_d = {lo_q[11:1], 1'b1};
          end
        end else
`endif
        begin
          // Shift hi[0] (now in K) into the top of lo.
          alu_op = OP_RKR;
          alu_b  = lo_q;
          lo_d   = alu_q;
          kReg_d = kOut;
        end
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = STEP0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: bench for alu_mul_seq. Supplies a behavioural 12-bit ALU,
// keeps an arithmetic reference model of the sequencer, checks it every cycle
// and adds directed vectors with hand-computed results.
// Define ALU_SEQ_DIV_EN to also exercise the divide path.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
`ifdef ALU_SEQ_DIV_EN
  logic        opDiv;
`endif
  logic [11:0] aIn, bIn;
  logic        busy, done;
  logic [11:0] resHi, resLo, aluA, aluB, aluQ;
  logic [4:0]  aluOp, aluFlg, aluFlgOut;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef ALU_SEQ_DIV_EN
    .op_div      (opDiv),
`endif
    .a_in        (aIn),
    .b_in        (bIn),
    .busy        (busy),
    .done        (done),
    .res_hi      (resHi),
    .res_lo      (resLo),
    .alu_a       (aluA),
    .alu_b       (aluB),
    .alu_op      (aluOp),
    .alu_flg     (aluFlg),
    .alu_q       (aluQ),
    .alu_flg_out (aluFlgOut)
  );

  // Behavioural ALU: ADD/SUB report carry/borrow in K, RKR/RKL rotate
  // through K, anything else passes B through.
  logic [12:0] aluSum;
  logic        aluKIn, aluKOut;
  always_comb begin
    aluSum  = '0;
    aluKIn  = aluFlg[2];
    aluKOut = aluKIn;
    aluQ    = aluB;
    case (aluOp)
      5'h04: begin
        aluSum  = {1'b0, aluA} + {1'b0, aluB};
        aluQ    = aluSum[11:0];
        aluKOut = aluSum[12];
      end
      5'h06: begin
        aluQ    = aluA - aluB;
        aluKOut = (aluA < aluB);
      end
      5'h0A: begin
        aluQ    = {aluB[10:0], aluKIn};
        aluKOut = aluB[11];
      end
      5'h0B: begin
        aluQ    = {aluKIn, aluB[11:1]};
        aluKOut = aluB[0];
      end
      default: ;
    endcase
    aluFlgOut = {2'b00, aluKOut, 1'b0, (aluQ == 12'h000)};
  end

  // Arithmetic reference: product, or quotient/remainder with the
  // divide-by-zero convention (quotient all ones, remainder = dividend).
  function automatic logic [23:0] modelResult(input logic [11:0] a,
                                              input logic [11:0] b,
                                              input bit div);
    logic [23:0] r;
    if (!div) begin
      r = {12'h000, a} * {12'h000, b};
    end else if (b == 12'h000) begin
      r = {a, 12'hFFF};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  // Cycle-level model: phase 0 = idle, 1..36 = computing, 37 = done cycle.
  int          phase = 0;
  logic [11:0] expHi = '0, expLo = '0;
  logic [23:0] pending = '0;
  bit          modelOn = 1'b0;
  bit          curDiv;

  always_comb begin
`ifdef ALU_SEQ_DIV_EN
    curDiv = opDiv;
`else
    curDiv = 1'b0;
`endif
  end

  always @(posedge clk) begin
    if (reset) begin
      phase <= 0;
      expHi <= '0;
      expLo <= '0;
    end else if ((phase == 0 || phase == 37) && start) begin
      phase   <= 1;
      pending <= modelResult(aIn, bIn, curDiv);
    end else if (phase >= 1 && phase <= 35) begin
      phase <= phase + 1;
    end else if (phase == 36) begin
      phase <= 37;
      expHi <= pending[23:12];
      expLo <= pending[11:0];
    end else begin
      phase <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [23:0] actual,
                             input logic [23:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("busy", {23'd0, busy}, {23'd0, (phase >= 1 && phase <= 36)});
      checkOutput("done", {23'd0, done}, {23'd0, (phase == 37)});
      checkOutput("flgMask", {19'd0, aluFlg & 5'b11011}, 24'd0);
      if (phase == 0 || phase == 37) begin
        checkOutput("resHi", {12'd0, resHi}, {12'd0, expHi});
        checkOutput("resLo", {12'd0, resLo}, {12'd0, expLo});
        checkOutput("idleOp", {19'd0, aluOp}, 24'd0);
        checkOutput("idleAB", {aluA, aluB}, 24'd0);
      end
    end
  end

  // Drive operands with a one-cycle start pulse; returns on the falling edge
  // of the first busy cycle. 'now' launches from the current falling edge.
  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b,
                               input bit div, input bit now);
    if (!now) @(negedge clk);
    aIn   = a;
    bIn   = b;
`ifdef ALU_SEQ_DIV_EN
    opDiv = div;
`else
    if (div) $display("[TB] divide vector skipped in multiply-only build");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then pin latency and result literals.
  task automatic waitDone(input string name, input int already,
                          input logic [11:0] wantHi, input logic [11:0] wantLo);
    int cycles;
    cycles = already;
    while (!done && cycles < 80) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, "_latency"}, cycles[23:0], 24'd37);
    checkOutput({name, "_hi"}, {12'd0, resHi}, {12'd0, wantHi});
    checkOutput({name, "_lo"}, {12'd0, resLo}, {12'd0, wantLo});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  busyCycles;
    bit  sawDone;
    reset = 1'b1;
    start = 1'b0;
    aIn   = '0;
    bIn   = '0;
`ifdef ALU_SEQ_DIV_EN
    opDiv = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_busyDone", {22'd0, busy, done}, 24'd0);
    checkOutput("rst_res", {resHi, resLo}, 24'd0);
    checkOutput("rst_aluAB", {aluA, aluB}, 24'd0);
    checkOutput("rst_opFlg", {14'd0, aluOp, aluFlg}, 24'd0);
    reset   = 1'b0;
    modelOn = 1'b1;

    // Largest operands; also count busy cycles explicitly.
    applyStimulus(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    busyCycles = 0;
    while (busy && busyCycles < 80) begin
      busyCycles++;
      @(negedge clk);
    end
    checkOutput("max_busyLen", busyCycles[23:0], 24'd36);
    checkOutput("max_doneNow", {23'd0, done}, 24'd1);
    checkOutput("max_hi", {12'd0, resHi}, 24'h000FFE);
    checkOutput("max_lo", {12'd0, resLo}, 24'h000001);

    applyStimulus(12'h123, 12'h010, 1'b0, 1'b0);
    waitDone("small", 1, 12'h001, 12'h230);
    applyStimulus(12'h000, 12'hABC, 1'b0, 1'b0);
    waitDone("zeroA", 1, 12'h000, 12'h000);
    applyStimulus(12'h800, 12'h002, 1'b0, 1'b0);
    waitDone("carryOut", 1, 12'h001, 12'h000);
    applyStimulus(12'hABC, 12'h001, 1'b0, 1'b0);
    waitDone("unitB", 1, 12'h000, 12'hABC);

    // Start held mid-operation with new operands must be ignored.
    applyStimulus(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    aIn   = 12'h555;
    bIn   = 12'h002;
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    waitDone("ignored", 15, 12'hFFE, 12'h001);

    // Back-to-back start issued in the done cycle.
    applyStimulus(12'h123, 12'h010, 1'b0, 1'b1);
    waitDone("backToBack", 1, 12'h001, 12'h230);

`ifdef ALU_SEQ_DIV_EN
    applyStimulus(12'h9C4, 12'h00A, 1'b1, 1'b0);
    waitDone("div", 1, 12'h000, 12'h0FA);
    applyStimulus(12'h07B, 12'h000, 1'b1, 1'b0);
    waitDone("divZero", 1, 12'h07B, 12'hFFF);
    applyStimulus(12'hFFF, 12'h007, 1'b1, 1'b0);
    waitDone("divMax", 1, 12'h000, 12'h249);
    applyStimulus(12'h3E8, 12'h800, 1'b1, 1'b0);
    waitDone("divBig", 1, 12'h3E8, 12'h000);
    applyStimulus(12'h064, 12'h007, 1'b1, 1'b0);
    waitDone("divRem", 1, 12'h002, 12'h00E);
`endif

    // Reset in the middle of an operation discards it.
    applyStimulus(12'hABC, 12'h123, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midRst_busyDone", {22'd0, busy, done}, 24'd0);
    checkOutput("midRst_res", {resHi, resLo}, 24'd0);
    checkOutput("midRst_op", {19'd0, aluOp}, 24'd0);
    sawDone = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("midRst_noDone", {23'd0, sawDone}, 24'd0);

    // Recovery after the reset.
    applyStimulus(12'h0FF, 12'h101, 1'b0, 1'b0);
    waitDone("afterRst", 1, 12'h00F, 12'hFFF);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that drives the 12-bit combinational ALU to compute a 12×12 unsigned multiply (24-bit product), with an optional unsigned divide. It owns the ALU's operand, operation and flag inputs while busy and keeps the carry flag in its own register between steps. It sits beside the execute stage. The core hands it operands with a start pulse and takes the result on a one-cycle done pulse.

## Interface
No parameters. Width is fixed at 12 bits.
- clk  in  1  system clock. All state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE or DONE.
- op_div  in  1  1 = divide, 0 = multiply. Present only with `ALU_SEQ_DIV_EN`.
- a_in  in  12  multiplicand, or dividend.
- b_in  in  12  multiplier, or divisor.
- busy  out  1  high while the operation is computing.
- done  out  1  one-cycle pulse when the result is valid.
- res_hi  out  12  product[23:12], or remainder.
- res_lo  out  12  product[11:0], or quotient.
- alu_a  out  12  ALU A operand.
- alu_b  out  12  ALU B operand.
- alu_op  out  5  ALU operation code.
- alu_flg  out  5  ALU flag input {P,V,K,S,Z}. Driven as {0,0,k_reg,0,0}.
- alu_q  in  12  ALU result. Used combinationally in the same cycle.
- alu_flg_out  in  5  ALU flag output. Bit 2 (K) is captured into k_reg.

## Operation
- Internal registers:
  - hi, lo (both 12 bits); these drive res_hi and res_lo directly.
  - mc (12 bits): multiplicand or divisor.
  - k_reg (1 bit).
  - cnt (4 bits), counts 0..11.
  - mode (1 bit).
- States: IDLE, STEP0, STEP1, STEP2, DONE. Bit iteration is STEP0 → STEP1 → STEP2.
- IDLE/DONE with start=1:
  - Multiply: hi←0, lo←b_in, mc←a_in.
  - Divide: hi←0, lo←a_in, mc←b_in.
  - In both cases k_reg←0, cnt←0, next state STEP0.
- IDLE/DONE with start=0: IDLE stays in IDLE. DONE moves to IDLE.
- Multiply, one bit iteration:
  - STEP0: alu_op=ADD (5'h04), A=hi, B=(lo[0] ? mc : 0). Then hi←alu_q and k_reg←carry.
  - STEP1: alu_op=RKR (5'h0B), B=hi. Then hi←alu_q and k_reg←K out.
  - STEP2: alu_op=RKR, B=lo. Then lo←alu_q and k_reg←K out.
- Divide (restoring), one bit iteration:
  - STEP0: alu_op=RKL (5'h0A), B=lo, with alu_flg K forced to 0. Then lo←alu_q and k_reg←K out.
  - STEP1: alu_op=RKL, B=hi. Then hi←alu_q. The K out is discarded.
  - STEP2: alu_op=SUB (5'h06), A=hi, B=mc.
    - If K out = 0 (no borrow): hi←alu_q and lo[0]←1.
    - Otherwise hi and lo are unchanged.
- After STEP2: if cnt=11, go to DONE; otherwise cnt←cnt+1 and go to STEP0.
- In IDLE and DONE: alu_op=5'h00 (MOV), alu_a=alu_b=0.
- Divide by zero has no special case. It yields quotient 0xFFF and remainder = a_in.
- start while busy is ignored. Inputs are not re-sampled.
- reset in any state:
  - state←IDLE.
  - hi, lo, mc, k_reg and cnt all ←0.
  - busy=0 and done=0 from the next cycle.
  - Any in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, res_hi=0, res_lo=0, alu_a=0, alu_b=0, alu_op=0, alu_flg=0.
- Start accepted at edge E0:
  - busy is high for cycles E0+1 through E0+36 (12 × 3 steps).
  - done is high for cycle E0+37 only, with busy low.
- Latency is a fixed 37 cycles from acceptance to done, independent of the operand data.
- res_hi and res_lo are valid from the done cycle. They hold until the next accepted start or reset.
- A start in the DONE cycle is accepted, which allows back-to-back operations every 37 cycles.
- The ALU is combinational. Each step completes in a single cycle with no wait states.

## Configuration
- `ALU_SEQ_DIV_EN` defined:
  - The op_div port, the mode register and the divide step decode are compiled in.
- `ALU_SEQ_DIV_EN` undefined:
  - The op_div port is absent and the block is multiply-only.
  - RKL and SUB are never issued.
  - Timing is identical.

## Test plan
- Multiply max: a=0xFFF, b=0xFFF, pulse start → done at +37 with res_hi=0xFFE, res_lo=0x001. busy is high for exactly 36 cycles.
- Multiply small: a=0x123, b=0x010 → res_hi=0x001, res_lo=0x230. Zero operand: a=0x000, b=0xABC → res_hi=0, res_lo=0.
- Ignored start: start held high for 5 cycles mid-operation with changed a_in/b_in → the original result is unaffected and there is a single done pulse. Then a back-to-back start in the DONE cycle → second done exactly 37 cycles later.
- Reset mid-operation: assert reset at cycle +20 → the next cycle shows busy=0, done=0, res_hi=res_lo=0 and alu_op=0. No done pulse follows.
- Divide (`ALU_SEQ_DIV_EN`): a=0x9C4, b=0x00A, op_div=1 → res_lo=0x0FA, res_hi=0x000. a=0x07B, b=0x000 → res_lo=0xFFF, res_hi=0x07B.
